// File: rtl/aes_dec_pkg.sv
// Shared AES-128 constants, S-box tables and GF(2^8) / key-schedule helpers
// for the iterative decrypt core.
package aes_dec_pkg;

  typedef enum logic [1:0] {IDLE, KEXP, ROUND} state_t;

  localparam int AES_ROUNDS = 10;

  localparam logic [7:0] RCON [AES_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX_TBL [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX_TBL [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[x];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[x];
  endfunction

  // Out-of-range indices read as zero so an idle counter never indexes past the table.
  function automatic logic [7:0] rcon_at(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    if (idx < 4'd10) r = RCON[idx];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] forward_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h000000};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undoes forward_expand: earlier words fall out of pairwise XORs of the later ones.
  function automatic logic [127:0] inverse_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/aes_dec_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless last_round is set.
module aes_dec_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [127:0] ark;
  logic [127:0] mix;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Row r rotates right by r columns, so the byte arrives from column c-r.
      localparam int SRC = 4 * ((c - r + 4) % 4) + r;
      localparam int DST = 4 * c + r;
      assign ark[127-8*DST -: 8] = inv_sbox(state_in[127-8*SRC -: 8]) ^ round_key[127-8*DST -: 8];
    end

    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[127-8*(4*c+0) -: 8];
    assign a1 = ark[127-8*(4*c+1) -: 8];
    assign a2 = ark[127-8*(4*c+2) -: 8];
    assign a3 = ark[127-8*(4*c+3) -: 8];

    assign mix[127-8*(4*c+0) -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign mix[127-8*(4*c+1) -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign mix[127-8*(4*c+2) -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign mix[127-8*(4*c+3) -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end

  assign state_out = last_round ? ark : mix;

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher, one inverse round per clock; the last round
// key is reached by running the forward key schedule before the rounds start.
//
// state | meaning
// IDLE  | waiting for AES_en; result and valid held
// KEXP  | forward key expansion rk0 -> rk10, initial AddRoundKey on the last step
// ROUND | inverse rounds 9..0, key schedule stepped backwards alongside
module aes_decrypt_core
  import aes_dec_pkg::*;
(
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);

  state_t       state, state_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic [127:0] st_reg, st_nxt;
  logic [127:0] key_reg, key_nxt;
  logic [127:0] out_nxt;
  logic         valid_nxt;

  logic [127:0] key_fwd;
  logic [127:0] rk_prev;
  logic [127:0] rnd_out;
  logic         last_round;

  assign key_fwd    = forward_expand(key_reg, rcon_at(cnt));
  assign rk_prev    = inverse_expand(key_reg, rcon_at(4'd9 - cnt));
  assign last_round = (cnt == 4'd9);

  aes_dec_round u_round (
    .state_in   (st_reg),
    .round_key  (rk_prev),
    .last_round (last_round),
    .state_out  (rnd_out)
  );

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state              <= IDLE;
      cnt                <= 4'd0;
      st_reg             <= '0;
      key_reg            <= '0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      st_reg             <= st_nxt;
      key_reg            <= key_nxt;
      AES_data_out       <= out_nxt;
      AES_data_out_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    st_nxt    = st_reg;
    key_nxt   = key_reg;
    out_nxt   = AES_data_out;
    valid_nxt = AES_data_out_valid;
    case (state)
      IDLE: begin
        if (AES_en) begin
          st_nxt    = AES_data_in;
          key_nxt   = AES_key_in;
          cnt_nxt   = 4'd0;
          valid_nxt = 1'b0;
          state_nxt = KEXP;
        end
      end
      KEXP: begin
        key_nxt = key_fwd;
        if (cnt == 4'd9) begin
          st_nxt    = st_reg ^ key_fwd;
          cnt_nxt   = 4'd0;
          state_nxt = ROUND;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ROUND: begin
        key_nxt = rk_prev;
        cnt_nxt = cnt + 4'd1;
        if (last_round) begin
          out_nxt   = rnd_out;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          st_nxt = rnd_out;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Self-checking bench for aes_decrypt_core: FIPS vectors, timing, reset and a
// round trip through an independent AES-128 encrypt model.
module tb_aes_decrypt_core;

  logic         AES_clk = 1'b0;
  logic         AES_rst_n = 1'b0;
  logic         AES_en = 1'b0;
  logic [127:0] AES_data_in = '0;
  logic [127:0] AES_key_in = '0;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sb [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  always #5 AES_clk = ~AES_clk;

  aes_decrypt_core dut (
    .AES_clk            (AES_clk),
    .AES_rst_n          (AES_rst_n),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] st, k;
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   rc;
    logic [31:0]  t;
    st = pt ^ key;
    k  = key;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      t = {sb[k[23:16]], sb[k[15:8]], sb[k[7:0]], sb[k[31:24]]} ^ {rc, 24'h000000};
      k[127:96] = k[127:96] ^ t;
      k[95:64]  = k[95:64] ^ k[127:96];
      k[63:32]  = k[63:32] ^ k[95:64];
      k[31:0]   = k[31:0] ^ k[63:32];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) a[i] = sb[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) b[4*c+w] = a[4*((c+w)%4)+w];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          a[4*c+0] = gm(b[4*c], 8'h02) ^ gm(b[4*c+1], 8'h03) ^ b[4*c+2] ^ b[4*c+3];
          a[4*c+1] = b[4*c] ^ gm(b[4*c+1], 8'h02) ^ gm(b[4*c+2], 8'h03) ^ b[4*c+3];
          a[4*c+2] = b[4*c] ^ b[4*c+1] ^ gm(b[4*c+2], 8'h02) ^ gm(b[4*c+3], 8'h03);
          a[4*c+3] = gm(b[4*c], 8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ gm(b[4*c+3], 8'h02);
        end else begin
          for (int w = 0; w < 4; w++) a[4*c+w] = b[4*c+w];
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = a[i] ^ k[127-8*i -: 8];
    end
    return st;
  endfunction

  task automatic pop_check(input string tag);
    logic [127:0] want;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 128'bx;
    check(tag, AES_data_out, want);
  endtask

  // Waits (bounded) for valid after the edge just passed; returns cycles waited.
  task automatic wait_valid(input bit churn, input bit probe, output int n);
    n = 0;
    while (!AES_data_out_valid && n < 40) begin
      if (churn) begin
        AES_data_in = {$urandom, $urandom, $urandom, $urandom};
        AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge AES_clk); #1;
      n++;
      if (probe && n == 10) check("rk10_probe", dut.key_reg, B_RK10);
    end
  endtask

  task automatic run_one(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt,
                         input bit churn, input bit probe, input string tag);
    int n;
    @(negedge AES_clk);
    AES_en = 1'b1;
    AES_data_in = ct;
    AES_key_in = key;
    exp_q.push_back(pt);
    @(posedge AES_clk); #1;
    AES_en = 1'b0;
    check({tag, "_valid_clr"}, 128'(AES_data_out_valid), 128'd0);
    wait_valid(churn, probe, n);
    check({tag, "_latency"}, 128'(n), 128'd20);
    pop_check({tag, "_data"});
  endtask

  initial begin
    int n;
    int vc;
    logic [127:0] pt, key;

    for (int x = 0; x < 256; x++) sb[x] = calc_sbox(8'(x));

    repeat (2) @(posedge AES_clk);
    #1;
    check("rst_data_out", AES_data_out, 128'd0);
    check("rst_valid", 128'(AES_data_out_valid), 128'd0);
    check("rst_key_reg", dut.key_reg, 128'd0);
    @(negedge AES_clk);
    AES_rst_n = 1'b1;

    run_one(C1_CT, C1_KEY, C1_PT, 1'b0, 1'b0, "c1");
    repeat (5) @(posedge AES_clk);
    #1;
    check("c1_hold_valid", 128'(AES_data_out_valid), 128'd1);
    check("c1_hold_data", AES_data_out, C1_PT);

    run_one(B_CT, B_KEY, B_PT, 1'b0, 1'b1, "appb");
    run_one(B_CT, B_KEY, B_PT, 1'b1, 1'b0, "churn");

    // Back-to-back with AES_en held high across three captures.
    @(negedge AES_clk);
    AES_en = 1'b1;
    AES_data_in = B_CT;
    AES_key_in = B_KEY;
    repeat (3) exp_q.push_back(B_PT);
    @(posedge AES_clk); #1;
    wait_valid(1'b0, 1'b0, n);
    check("b2b_lat1", 128'(n), 128'd20);
    pop_check("b2b_data1");
    @(posedge AES_clk); #1;
    check("b2b_drop1", 128'(AES_data_out_valid), 128'd0);
    wait_valid(1'b0, 1'b0, n);
    check("b2b_lat2", 128'(n), 128'd20);
    pop_check("b2b_data2");
    @(posedge AES_clk); #1;
    check("b2b_drop2", 128'(AES_data_out_valid), 128'd0);
    AES_en = 1'b0;
    wait_valid(1'b0, 1'b0, n);
    check("b2b_lat3", 128'(n), 128'd20);
    pop_check("b2b_data3");
    repeat (3) @(posedge AES_clk);
    #1;
    check("b2b_hold_valid", 128'(AES_data_out_valid), 128'd1);

    // Reset mid-run, then confirm nothing is flagged and a fresh run works.
    @(negedge AES_clk);
    AES_en = 1'b1;
    AES_data_in = C1_CT;
    AES_key_in = C1_KEY;
    @(posedge AES_clk); #1;
    AES_en = 1'b0;
    repeat (15) @(posedge AES_clk);
    #1;
    AES_rst_n = 1'b0;
    #1;
    check("midrst_data_out", AES_data_out, 128'd0);
    check("midrst_valid", 128'(AES_data_out_valid), 128'd0);
    check("midrst_state", 128'(dut.state), 128'd0);
    check("midrst_cnt", 128'(dut.cnt), 128'd0);
    check("midrst_st_reg", dut.st_reg, 128'd0);
    @(negedge AES_clk);
    AES_rst_n = 1'b1;
    vc = 0;
    repeat (30) begin
      @(posedge AES_clk); #1;
      if (AES_data_out_valid) vc++;
    end
    check("midrst_no_valid", 128'(vc), 128'd0);
    run_one(B_CT, B_KEY, B_PT, 1'b0, 1'b0, "post_rst");

    for (int v = 0; v < 128; v++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      run_one(enc(pt, key), key, pt, 1'b0, 1'b0, "rt");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
